// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default frame geometry and
// the idle line level. Used by both the transmit and the receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int unsigned DATA_BITS_DEFAULT  = 8;
    localparam int unsigned OVERSAMPLE_DEFAULT = 16;
    localparam logic        IDLE_LEVEL         = 1'b1;

endpackage

// File: rtl/uart_tx_tick_counter.sv
// Transmit bit-period timer: counts sample_en ticks while a frame is active
// and flags the tick that closes the current bit period. Mirrors the
// receive-side sample counter so both directions share one baud source.
module uart_tx_tick_counter
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic active,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned         TICK_W   = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0]   TICK_MAX = TICK_W'(OVERSAMPLE - 1);

    logic [TICK_W-1:0] tick;

    // Bit ends on the last tick of the period; one clk wide like sample_en.
    assign bit_end = active && sample_en && (tick == TICK_MAX);

    // Tick count: cleared on reset or frame acceptance, advances per strobe.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick <= '0;
        end else if (active && sample_en) begin
            tick <= bit_end ? '0 : tick + TICK_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a byte on tx_load && tx_ready and sends it
// LSB-first as start, DATA_BITS data bits, optional even parity, stop.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEFAULT,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_load,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned      BIT_W    = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 tx_out_next;
    logic                 done_next;
    logic                 accept;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign accept   = tx_load && (state == IDLE);

    uart_tx_tick_counter #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .active    (tx_busy),
        .clear     (accept),
        .bit_end   (bit_end)
    );

    // Frame state, data shifter and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx_out    <= IDLE_LEVEL;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            tx_out    <= tx_out_next;
            tx_done   <= done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured at acceptance because the shifter consumes the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^tx_data;
        end
    end
`endif

    // Next-state logic; tx_out is derived from the next state so the line
    // changes in the same cycle the state does.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        done_next    = 1'b0;
        tx_out_next  = IDLE_LEVEL;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = START;
                    shift_next   = tx_data;
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_out_next = 1'b0;
            DATA:    tx_out_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_next = parity_bit;
`endif
            default: tx_out_next = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer (8 data bits,
// 16 ticks per bit). Define UART_TX_PARITY_EN for the parity build.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready, tx_out, tx_busy, tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_serializer #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for bit index idx of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic accept(input logic [7:0] d);
        tx_data   = d;
        tx_load   = 1'b1;
        sample_en = 1'b1;
        step();
        tx_load   = 1'b0;
    endtask

    // Walks a frame cycle by cycle after acceptance. sample_en fires for
    // edge c when c is a multiple of period; inject > 0 pulses a load of
    // 0x12 in that cycle; chain loads chain_d in the tx_done cycle.
    task automatic check_frame(input string name, input logic [7:0] d, input int period,
                               input int inject, input bit chain, input logic [7:0] chain_d);
        int bitlen = 16 * period;
        int total  = FRAME_BITS * bitlen;
        for (int c = 1; c <= total + 1; c++) begin
            if (c <= total) begin
                check($sformatf("%s tx_out c%0d", name, c), 32'(tx_out), 32'(exp_bit(d, (c - 1) / bitlen)));
                check($sformatf("%s busy c%0d", name, c), 32'(tx_busy), 32'd1);
                check($sformatf("%s done c%0d", name, c), 32'(tx_done), 32'd0);
            end else begin
                check($sformatf("%s idle tx_out c%0d", name, c), 32'(tx_out), 32'd1);
                check($sformatf("%s done c%0d", name, c), 32'(tx_done), 32'd1);
                check($sformatf("%s ready c%0d", name, c), 32'(tx_ready), 32'd1);
                check($sformatf("%s busy c%0d", name, c), 32'(tx_busy), 32'd0);
            end
            sample_en = ((c % period) == 0);
            tx_load   = 1'b0;
            if (c == inject) begin
                tx_load = 1'b1;
                tx_data = 8'h12;
            end
            if (c == total + 1 && chain) begin
                tx_load = 1'b1;
                tx_data = chain_d;
            end
            step();
        end
        tx_load = 1'b0;
        if (!chain) check($sformatf("%s done clears", name), 32'(tx_done), 32'd0);
    endtask

    initial begin
        // Reset state, with sample_en active to show IDLE ignores it.
        sample_en = 1'b1;
        repeat (3) step();
        check("rst tx_out", 32'(tx_out), 32'd1);
        check("rst ready", 32'(tx_ready), 32'd1);
        check("rst busy", 32'(tx_busy), 32'd0);
        check("rst done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        repeat (5) step();
        check("idle tx_out", 32'(tx_out), 32'd1);

        // Frame timing with a strobe every cycle.
        accept(8'h55);
        check_frame("f55", 8'h55, 1, 0, 1'b0, 8'h00);

        // Sparse tick: one strobe every 4th cycle.
        accept(8'hA3);
        check_frame("fA3", 8'hA3, 4, 0, 1'b0, 8'h00);

        // Back-to-back: load held in the tx_done cycle.
        accept(8'h00);
        check_frame("f00", 8'h00, 1, 0, 1'b1, 8'hFF);
        check_frame("fFF", 8'hFF, 1, 0, 1'b0, 8'h00);

        // Load during DATA is ignored; no follow-up frame.
        accept(8'h3C);
        check_frame("f3C", 8'h3C, 1, 40, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) begin
            check($sformatf("no extra frame tx_out %0d", i), 32'(tx_out), 32'd1);
            check($sformatf("no extra frame busy %0d", i), 32'(tx_busy), 32'd0);
            step();
        end

        // Parity build frame (plain 10-bit frame otherwise).
        accept(8'h07);
        check_frame("f07", 8'h07, 1, 0, 1'b0, 8'h00);

        // Reset during data bit 3 (bit 3 of 0xF7 is 0).
        accept(8'hF7);
        sample_en = 1'b1;
        for (int c = 1; c < 70; c++) step();
        check("mid-frame tx_out before rst", 32'(tx_out), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort tx_out", 32'(tx_out), 32'd1);
        check("abort ready", 32'(tx_ready), 32'd1);
        check("abort busy", 32'(tx_busy), 32'd0);
        check("abort done", 32'(tx_done), 32'd0);
        for (int i = 0; i < 200; i++) begin
            check($sformatf("post-abort done %0d", i), 32'(tx_done), 32'd0);
            check($sformatf("post-abort tx_out %0d", i), 32'(tx_out), 32'd1);
            step();
        end

        // Reset wins over a simultaneous load.
        tx_data = 8'h00;
        tx_load = 1'b1;
        rst     = 1'b1;
        step();
        tx_load = 1'b0;
        rst     = 1'b0;
        check("rst prio busy", 32'(tx_busy), 32'd0);
        check("rst prio tx_out", 32'(tx_out), 32'd1);
        step();
        check("rst prio still idle", 32'(tx_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
